// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH clocks, LSB first, start/busy/done handshake.
// Optional signed-overflow output ovf is built when SERSUB_OVF_EN is defined.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_reg;
  logic             borrow_reg;
  logic [CW-1:0]    count_reg;

  logic             x;
  logic             y;
  logic             d;
  logic             c_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // One full-subtract cell, reused for every bit position.
  assign x        = a_sh_reg[0];
  assign y        = b_sh_reg[0];
  assign d        = x ^ y ^ borrow_reg;
  assign c_next   = (~x & y) | (~x & borrow_reg) | (y & borrow_reg);
  assign last_bit = (state_reg == RUN) && (count_reg == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = d;
    end else begin : g_res_wn
      assign res_next = {d, res_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      count_reg  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      bout       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= bin;
            count_reg  <= '0;
            busy       <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          borrow_reg <= c_next;
          res_reg    <= res_next;
          count_reg  <= count_reg + 1'b1;
          // Outputs only move here, so diff/bout stay stable through RUN.
          if (last_bit) begin
            diff      <= res_next;
            bout      <= c_next;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SERSUB_OVF_EN
  logic a_msb_reg;
  logic b_msb_reg;

  // Sign bits are captured at accept since the shift regs lose them during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf       <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
    end else if (last_bit) begin
      ovf <= (a_msb_reg != b_msb_reg) && (d != a_msb_reg);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: WIDTH=8 and WIDTH=1 instances, directed vectors.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic       start8, bin8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start1, a1, b1, bin1, busy1, done1, bout1, ovf1;
  logic [0:0] diff1;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8;
  exp_t e1;

  // {diff, bout} and ovf for the WIDTH=1 build, indexed by {a, b, bin}.
  logic [1:0] tbl1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
  logic [7:0] ovf1_tbl = 8'b0010_0100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERSUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERSUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

`ifndef SERSUB_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitors: pop the scoreboard whenever a done pulse is seen.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8_unexpected_done actual=done required=no_done diff=%h", diff8);
      end else begin
        e8 = q8.pop_front();
        $display("txn w8 diff=%h bout=%b cyc=%0d", diff8, bout8, cyc);
        chk("w8_diff", 32'(diff8), 32'(e8.diff));
        chk("w8_bout", 32'(bout8), 32'(e8.bout));
        chk("w8_latency_cyc", cyc, e8.cyc);
`ifdef SERSUB_OVF_EN
        chk("w8_ovf", 32'(ovf8), 32'(e8.ovf));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w1_unexpected_done actual=done required=no_done diff=%b", diff1);
      end else begin
        e1 = q1.pop_front();
        $display("txn w1 diff=%b bout=%b cyc=%0d", diff1, bout1, cyc);
        chk("w1_diff", 32'(diff1), 32'(e1.diff[0]));
        chk("w1_bout", 32'(bout1), 32'(e1.bout));
        chk("w1_latency_cyc", cyc, e1.cyc);
`ifdef SERSUB_OVF_EN
        chk("w1_ovf", 32'(ovf1), 32'(e1.ovf));
`endif
      end
    end
  end

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic push,
                        input logic [7:0] ed, input logic eb, input logic eo);
    a8 = av; b8 = bv; bin8 = cv; start8 = 1'b1;
    if (push) q8.push_back('{diff: ed, bout: eb, ovf: eo, cyc: cyc + 1 + 8});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'hA5; b8 = 8'h5A; bin8 = 1'b1;
  endtask

  task automatic issue1(input logic av, input logic bv, input logic cv,
                        input logic ed, input logic eb, input logic eo);
    a1 = av; b1 = bv; bin1 = cv; start1 = 1'b1;
    q1.push_back('{diff: {7'b0, ed}, bout: eb, ovf: eo, cyc: cyc + 1 + 1});
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~av; b1 = ~bv; bin1 = ~cv;
  endtask

  task automatic wait_empty8();
    for (int n = 0; n < 40; n++) begin
      if (q8.size() == 0) break;
      @(negedge clk);
    end
    if (q8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL w8_timeout actual=pending:%0d required=pending:0", q8.size());
      q8.delete();
    end
  endtask

  task automatic wait_empty1();
    for (int n = 0; n < 10; n++) begin
      if (q1.size() == 0) break;
      @(negedge clk);
    end
    if (q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL w1_timeout actual=pending:%0d required=pending:0", q1.size());
      q1.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy8", 32'(busy8), 0);
    chk("reset_done8", 32'(done8), 0);
    chk("reset_diff8", 32'(diff8), 0);
    chk("reset_bout8", 32'(bout8), 0);
    chk("reset_busy1", 32'(busy1), 0);
    chk("reset_done1", 32'(done1), 0);
    chk("reset_diff1", 32'(diff1), 0);
    chk("reset_bout1", 32'(bout1), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue8(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0);
    wait_empty8();
    issue8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_empty8();
    issue8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    wait_empty8();
    issue8(8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    wait_empty8();

    // Start while busy must be ignored; start in the done cycle must be taken.
    issue8(8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    issue8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      if (done8 === 1'b1) break;
      @(negedge clk);
    end
    issue8(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
    wait_empty8();

    // Reset in the middle of RUN discards the operation.
    issue8(8'h77, 8'h22, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    q8.delete();
    chk("midreset_busy8", 32'(busy8), 0);
    chk("midreset_done8", 32'(done8), 0);
    chk("midreset_diff8", 32'(diff8), 0);
    chk("midreset_bout8", 32'(bout8), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue8(8'h77, 8'h22, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    wait_empty8();

    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      logic [1:0] ent;
      idx = 3'(i);
      ent = tbl1[i];
      issue1(idx[2], idx[1], idx[0], ent[1], ent[0], ovf1_tbl[i]);
      wait_empty1();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
